// File: rtl/arb_br_pkg.sv
// rtl/arb_br_pkg.sv - shared types and constants for the register-bank write arbiter
//
// Purpose : state encoding, reserved register address and default widths used by
//           arbitro_escritura_br and its rotating priority encoder.
// Ports   : none (package).
package arb_br_pkg;

    // Default register address / data widths of the bank.
    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

    // Register 0 is hard-wired to zero; writes to it are accepted and dropped.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Arbiter states: ARB picks round-robin, LOCK keeps the port for one owner.
    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Next round-robin pointer: one past the winner, wrapping at nreq.
    function automatic int next_ptr(input int winner, input int nreq);
        return (winner >= nreq - 1) ? 0 : winner + 1;
    endfunction

endpackage

// File: rtl/arbitro_escritura_br_rr_prioridad.sv
// rtl/arbitro_escritura_br_rr_prioridad.sv - combinational rotating priority encoder
//
// Purpose : finds the first asserted request searching upward from rr_ptr,
//           wrapping from NREQ-1 to 0.
// Ports   : req    in  NREQ          request vector
//           rr_ptr in  clog2(NREQ)   highest-priority index this cycle (< NREQ)
//           gnt    out NREQ          one-hot grant, all zero when req is zero
//           idx    out clog2(NREQ)   index of the granted bit (0 when none)
module rr_prioridad #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] rr_ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IW = $clog2(NREQ);

    int pos;

    // Walk the rotated order from the lowest priority to the highest so the
    // last hit (smallest offset from rr_ptr) is the one that survives.
    always_comb begin
        gnt = '0;
        idx = '0;
        pos = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (req[pos]) begin
                gnt      = '0;
                gnt[pos] = 1'b1;
                idx      = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/arbitro_escritura_br.sv
// rtl/arbitro_escritura_br.sv - round-robin arbiter for the register-bank write port
//
// Purpose : shares the single Write/WA/WD port among NREQ writeback sources with
//           valid/ready handshakes, round-robin fairness and lockable bursts.
//           Optional build macro: ARB_GRANT_CNT_EN adds the grant_cnt output.
// Ports   : clk        in  1            clock, rising edge
//           rst        in  1            synchronous active-high reset
//           stall      in  1            blocks new grants while high
//           req_valid  in  NREQ         per-requester write request
//           req_lock   in  NREQ         keep the grant for the next cycle
//           req_wa     in  NREQ*AW      packed addresses, requester i at [i*AW +: AW]
//           req_wd     in  NREQ*DW      packed data, requester i at [i*DW +: DW]
//           req_ready  out NREQ         one-hot combinational grant
//           Write      out 1            registered bank write enable
//           WA         out AW           registered bank write address
//           WD         out DW           registered bank write data
//           grant_cnt  out 16           handshake counter (ARB_GRANT_CNT_EN only)
//           grant_id   out clog2(NREQ)  requester owning the registered write
module arbitro_escritura_br
    import arb_br_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_lock,
    input  logic [NREQ*AW-1:0]      req_wa,
    input  logic [NREQ*DW-1:0]      req_wd,
    output logic [NREQ-1:0]         req_ready,
    output logic                    Write,
    output logic [AW-1:0]           WA,
    output logic [DW-1:0]           WD,
`ifdef ARB_GRANT_CNT_EN
    output logic [15:0]             grant_cnt,
`endif
    output logic [$clog2(NREQ)-1:0] grant_id
);

    localparam int IW = $clog2(NREQ);

    localparam logic [0:0] ST_ARB  = ARB;
    localparam logic [0:0] ST_LOCK = LOCK;

    logic [0:0]      state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   lock_id;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic [NREQ-1:0] ready;
    logic [IW-1:0]   win_idx;
    logic            handshake;
    logic [AW-1:0]   wa_sel;
    logic [DW-1:0]   wd_sel;
    logic [IW-1:0]   rr_next;

    rr_prioridad #(
        .NREQ (NREQ)
    ) u_rr_prioridad (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .gnt    (arb_gnt),
        .idx    (arb_idx)
    );

    // Grant is combinational so a source sees ready in the same cycle it asks.
    // Reset and stall both suppress it; in LOCK only the owner may be granted.
    always_comb begin
        ready = '0;
        if (!rst && !stall) begin
            if (state == ST_ARB) begin
                ready = arb_gnt;
            end else if (req_valid[lock_id]) begin
                ready[lock_id] = 1'b1;
            end
        end
    end

    assign req_ready = ready;
    assign handshake = |(req_valid & ready);
    assign win_idx   = (state == ST_LOCK) ? lock_id : arb_idx;
    assign wa_sel    = req_wa[int'(win_idx) * AW +: AW];
    assign wd_sel    = req_wd[int'(win_idx) * DW +: DW];
    assign rr_next   = IW'(next_ptr(int'(win_idx), NREQ));

    // Arbitration state: pointer rotation and lock ownership.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_ARB;
            rr_ptr  <= '0;
            lock_id <= '0;
        end else begin
            if (handshake) begin
                rr_ptr <= rr_next;
            end
            case (state)
                ST_ARB: begin
                    if (handshake && req_lock[win_idx]) begin
                        state   <= ST_LOCK;
                        lock_id <= win_idx;
                    end
                end
                default: begin
                    // A stall freezes the burst; otherwise the owner either
                    // finishes (lock dropped) or abandons it (valid dropped).
                    if (!stall) begin
                        if (!req_valid[lock_id]) begin
                            state <= ST_ARB;
                        end else if (!req_lock[lock_id]) begin
                            state <= ST_ARB;
                        end
                    end
                end
            endcase
        end
    end

    // Registered bank port. Address/data/id hold between handshakes; only the
    // enable pulses. A register-0 target still latches WA/WD but never writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            Write    <= 1'b0;
            WA       <= '0;
            WD       <= '0;
            grant_id <= '0;
        end else if (handshake) begin
            Write    <= (wa_sel != AW'(REG_ZERO));
            WA       <= wa_sel;
            WD       <= wd_sel;
            grant_id <= win_idx;
        end else begin
            Write    <= 1'b0;
        end
    end

`ifdef ARB_GRANT_CNT_EN
    // Counts every accepted transfer, dropped register-0 writes included.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt <= '0;
        end else if (handshake) begin
            grant_cnt <= grant_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_arbitro_escritura_br.sv
// tb/tb_arbitro_escritura_br.sv - self-checking bench for arbitro_escritura_br
module tb_arbitro_escritura_br;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int IW   = $clog2(NREQ);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 stall;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_lock;
    logic [NREQ*AW-1:0]   req_wa;
    logic [NREQ*DW-1:0]   req_wd;
    logic [NREQ-1:0]      req_ready;
    logic                 Write;
    logic [AW-1:0]        WA;
    logic [DW-1:0]        WD;
    logic [IW-1:0]        grant_id;
`ifdef ARB_GRANT_CNT_EN
    logic [15:0]          grant_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    bit checking = 1'b0;

    // Behavioural model: owner < 0 means no burst in progress.
    int            m_rr    = 0;
    int            m_owner = -1;
    logic          m_write = 1'b0;
    logic [AW-1:0] m_wa    = '0;
    logic [DW-1:0] m_wd    = '0;
    int            m_gid   = 0;
    int            m_cnt   = 0;

    int rot_wa[4]  = '{1, 2, 3, 1};
    int rot_gid[4] = '{0, 1, 2, 0};

    always #5 clk = ~clk;

    arbitro_escritura_br #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .req_wa    (req_wa),
        .req_wd    (req_wd),
        .req_ready (req_ready),
        .Write     (Write),
        .WA        (WA),
        .WD        (WD),
`ifdef ARB_GRANT_CNT_EN
        .grant_cnt (grant_cnt),
`endif
        .grant_id  (grant_id)
    );

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        req_wa[i*AW +: AW] = wa;
        req_wd[i*DW +: DW] = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Who may transfer right now, from the rules rather than any state encoding.
    function automatic logic [NREQ-1:0] model_ready();
        logic [NREQ-1:0] r;
        r = '0;
        if (rst || stall) return r;
        if (m_owner >= 0) begin
            if (req_valid[m_owner]) r[m_owner] = 1'b1;
            return r;
        end
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_rr + k) % NREQ]) begin
                r[(m_rr + k) % NREQ] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    initial begin : model
        logic [NREQ-1:0] r;
        int w;
        forever begin
            @(posedge clk);
            r = model_ready();
            if (rst) begin
                m_write = 1'b0; m_wa = '0; m_wd = '0; m_gid = 0;
                m_rr = 0; m_owner = -1; m_cnt = 0;
            end else if (r != '0) begin
                w = 0;
                for (int i = 0; i < NREQ; i++) if (r[i]) w = i;
                m_wa    = req_wa[w*AW +: AW];
                m_wd    = req_wd[w*DW +: DW];
                m_write = (m_wa != 0);
                m_gid   = w;
                m_rr    = (w + 1) % NREQ;
                m_owner = req_lock[w] ? w : -1;
                m_cnt   = (m_cnt + 1) % 65536;
            end else begin
                m_write = 1'b0;
                if (m_owner >= 0 && !stall && !req_valid[m_owner]) m_owner = -1;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (checking) begin
                cmp("model_ready", req_ready, model_ready());
                cmp("model_write", Write, m_write);
                cmp("model_wa", WA, m_wa);
                cmp("model_wd", WD, m_wd);
                cmp("model_gid", grant_id, m_gid);
`ifdef ARB_GRANT_CNT_EN
                cmp("model_cnt", grant_cnt, m_cnt);
`endif
            end
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; req_valid = '1; req_lock = '0;
        req_wa = '0; req_wd = '0;
        set_req(0, 5'd1, 32'hA); set_req(1, 5'd2, 32'hB); set_req(2, 5'd3, 32'hC);

        // Reset held two cycles with everyone requesting.
        tick();
        checking = 1'b1;
        tick();
        #1;
        cmp("rst_ready", req_ready, 3'b000);
        cmp("rst_write", Write, 1'b0);
        rst = 1'b0;
        #1;
        cmp("first_grant", req_ready, 3'b001);

        // Rotation 0,1,2,0.
        for (int i = 0; i < 4; i++) begin
            tick();
            cmp("rot_wa", WA, rot_wa[i]);
            cmp("rot_gid", grant_id, rot_gid[i]);
            cmp("rot_write", Write, 1'b1);
        end

        // Register-0 write is accepted and dropped.
        req_valid = 3'b010;
        set_req(1, 5'd0, 32'hDEADBEEF);
        #1;
        cmp("r0_ready", req_ready, 3'b010);
        tick();
        cmp("r0_write", Write, 1'b0);
        cmp("r0_wa", WA, 5'd0);
        cmp("r0_wd", WD, 32'hDEADBEEF);

        // Locked burst from requester 2 while 0 and 1 wait.
        req_valid = 3'b111; req_lock = 3'b100;
        set_req(1, 5'd2, 32'hB); set_req(2, 5'd30, 32'h1E);
        #1;
        cmp("lock_first_ready", req_ready, 3'b100);
        tick();
        cmp("lock_wa0", WA, 5'd30);
        set_req(2, 5'd31, 32'h1F); req_lock = 3'b000;
        #1;
        cmp("lock_hold_ready", req_ready, 3'b100);
        tick();
        cmp("lock_wa1", WA, 5'd31);
        cmp("lock_gid1", grant_id, 2);
        #1;
        cmp("lock_after_ready", req_ready, 3'b001);
        tick();
        cmp("lock_next_gid", grant_id, 0);
        cmp("lock_next_wa", WA, 5'd1);

        // Stall for three cycles.
        req_valid = 3'b001; stall = 1'b1;
        #1;
        cmp("stall_ready", req_ready, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("stall_write", Write, 1'b0);
            cmp("stall_ready_hold", req_ready, 3'b000);
        end
        stall = 1'b0;
        #1;
        cmp("unstall_ready", req_ready, 3'b001);
        tick();
        cmp("unstall_write", Write, 1'b1);
        cmp("unstall_gid", grant_id, 0);

        // Reset in the middle of a lock.
        req_valid = 3'b010; req_lock = 3'b010;
        set_req(1, 5'd7, 32'h77);
        tick();
        cmp("ml_write", Write, 1'b1);
        cmp("ml_wa", WA, 5'd7);
        rst = 1'b1;
        #1;
        cmp("ml_rst_ready", req_ready, 3'b000);
        tick();
        cmp("ml_rst_write", Write, 1'b0);
`ifdef ARB_GRANT_CNT_EN
        cmp("ml_rst_cnt", grant_cnt, 16'd0);
`endif
        rst = 1'b0; req_valid = 3'b001; req_lock = 3'b000;
        #1;
        cmp("ml_arb_ready", req_ready, 3'b001);
        tick();
        cmp("ml_arb_gid", grant_id, 0);

        // Burst abandoned by the owner dropping valid.
        req_valid = 3'b100; req_lock = 3'b100;
        set_req(2, 5'd5, 32'h55);
        tick();
        cmp("ab_wa", WA, 5'd5);
        req_valid = 3'b001;
        #1;
        cmp("ab_lock_ready", req_ready, 3'b000);
        tick();
        cmp("ab_write", Write, 1'b0);
        req_lock = 3'b000;
        #1;
        cmp("ab_arb_ready", req_ready, 3'b001);
        tick();
        cmp("ab_gid", grant_id, 0);

        req_valid = '0;
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
